// File: rtl/uart_tx_scheduler_if.sv
// rtl/uart_tx_scheduler_if.sv - requester and transmitter handshake bundle for uart_tx_scheduler
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int WIDTH   = 8
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       ack;
  logic                     tx_start;
  logic [WIDTH-1:0]         tx_data;
  logic                     tx_busy;
  logic [ID_W-1:0]          active_id;
  logic                     done;
  logic                     timeout_err;
  logic                     err_sticky;
  logic                     idle;

  // Client logic and transmitter side
  modport master (
    output req, req_data, tx_busy,
    input  ack, tx_start, tx_data, active_id, done, timeout_err, err_sticky, idle
  );

  // Scheduler side
  modport slave (
    input  req, req_data, tx_busy,
    output ack, tx_start, tx_data, active_id, done, timeout_err, err_sticky, idle
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin arbiter sharing one UART transmitter with start timeout
module uart_tx_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input logic               clk,
  input logic               rst,
  uart_tx_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [ID_W-1:0]    ptr_q;
  logic [15:0]        cnt_q;
  logic [15:0]        cnt_d;
  logic [NUM_REQ-1:0] ack_q;
  logic               tx_start_q;
  logic [WIDTH-1:0]   tx_data_q;
  logic [ID_W-1:0]    active_id_q;
  logic               done_q;
  logic               timeout_err_q;
  logic               err_sticky_q;
  logic               idle_q;

  logic               grant_vld;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    cand;
  logic [ID_W-1:0]    next_ptr;

  // Index arithmetic modulo NUM_REQ; v is always below 2*NUM_REQ here
  function automatic logic [ID_W-1:0] wrap_id(input int unsigned v);
    if (v >= NUM_REQ) begin
      return ID_W'(v - NUM_REQ);
    end
    return ID_W'(v);
  endfunction

  // Pick the first pending requester at or above ptr, wrapping; scanning
  // downward lets the candidate closest to ptr overwrite the others
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = wrap_id(32'(ptr_q) + 32'(k));
      if (bus.req[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  assign next_ptr = wrap_id(32'(active_id_q) + 32'd1);
  assign cnt_d    = cnt_q + 16'd1;

  // Scheduler FSM; every output is a register so nothing leaks combinationally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      ack_q         <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      active_id_q   <= '0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      err_sticky_q  <= 1'b0;
      idle_q        <= 1'b1;
    end else begin
      ack_q         <= '0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_vld) begin
            ack_q[grant_id] <= 1'b1;
            tx_data_q       <= bus.req_data[grant_id*WIDTH +: WIDTH];
            active_id_q     <= grant_id;
            cnt_q           <= '0;
            tx_start_q      <= 1'b1;
            idle_q          <= 1'b0;
            state_q         <= S_START;
          end
        end
        S_START: begin
          // A busy rise on the terminal count wins over the timeout
          if (bus.tx_busy) begin
            tx_start_q <= 1'b0;
            state_q    <= S_WAIT_DONE;
          end else if (cnt_q == 16'(TIMEOUT - 1)) begin
            timeout_err_q <= 1'b1;
            err_sticky_q  <= 1'b1;
            ptr_q         <= next_ptr;
            tx_start_q    <= 1'b0;
            idle_q        <= 1'b1;
            state_q       <= S_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_WAIT_DONE: begin
          if (!bus.tx_busy) begin
            done_q  <= 1'b1;
            ptr_q   <= next_ptr;
            idle_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          tx_start_q <= 1'b0;
          idle_q     <= 1'b1;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ack         = ack_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.active_id   = active_id_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.err_sticky  = err_sticky_q;
  assign bus.idle        = idle_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_tx_scheduler_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .WIDTH(WIDTH)) bus ();

  uart_tx_scheduler #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Transmitter model: raises busy on the (busy_delay+1)-th cycle tx_start is seen, holds frame_len cycles
  int busy_delay = -1;
  int frame_len  = 1;
  int seen       = 0;
  int busy_left  = 0;

  int n_ack, n_done, n_tmo, n_start, last_ack_cyc, last_tmo_cyc;

  logic [WIDTH-1:0]   bytes [NUM_REQ];
  logic [NUM_REQ-1:0] req_v;

  // Reference arbitration: first requester at or above p, modulo NUM_REQ
  function automatic int model_pick(input logic [NUM_REQ-1:0] r, input int p);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic drive_req();
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*WIDTH +: WIDTH] = bytes[i];
    bus.req = req_v;
  endtask

  task automatic clear_obs();
    n_ack = 0; n_done = 0; n_tmo = 0; n_start = 0; last_ack_cyc = 0; last_tmo_cyc = 0;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.ack != '0) begin n_ack++; last_ack_cyc = cyc; end
    if (bus.done) n_done++;
    if (bus.timeout_err) begin n_tmo++; last_tmo_cyc = cyc; end
    if (bus.tx_start) n_start++;
    if (bus.tx_busy) begin
      if (busy_left <= 1) bus.tx_busy = 1'b0;
      else busy_left--;
    end else if (bus.tx_start) begin
      seen++;
      if (busy_delay >= 0 && seen == busy_delay + 1) begin
        bus.tx_busy = 1'b1;
        busy_left   = frame_len;
        seen        = 0;
      end
    end else begin
      seen = 0;
    end
  endtask

  task automatic wait_ack(input int budget, output bit ok);
    int start;
    start = n_ack;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (n_ack != start) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int start;
    start = n_done;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (n_done != start) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_tmo(input int budget, output bit ok);
    int start;
    start = n_tmo;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (n_tmo != start) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_v = '0;
    drive_req();
    bus.tx_busy = 1'b0;
    seen = 0;
    busy_left = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    clear_obs();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b exp=1", bus.idle); end
    checks++; if (bus.ack !== '0) begin errors++; $display("FAIL reset_ack got=%b exp=0", bus.ack); end
    checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got=%b exp=0", bus.tx_start); end
    checks++; if (bus.tx_data !== '0) begin errors++; $display("FAIL reset_tx_data got=%h exp=0", bus.tx_data); end
    checks++; if (bus.active_id !== '0) begin errors++; $display("FAIL reset_active_id got=%0d exp=0", bus.active_id); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got=%b exp=0", bus.timeout_err); end
    checks++; if (bus.err_sticky !== 1'b0) begin errors++; $display("FAIL reset_err_sticky got=%b exp=0", bus.err_sticky); end
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    busy_delay = 2; frame_len = 20;
    bytes[0] = 8'hA5;
    for (int i = 1; i < NUM_REQ; i++) bytes[i] = WIDTH'($urandom);
    req_v = 4'b0001;
    drive_req();
    wait_ack(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_grant got=none exp=ack"); end
    checks++; if (bus.ack !== 4'b0001) begin errors++; $display("FAIL single_ack got=%b exp=0001", bus.ack); end
    checks++; if (bus.tx_data !== 8'hA5) begin errors++; $display("FAIL single_tx_data got=%h exp=a5", bus.tx_data); end
    checks++; if (bus.active_id !== 2'd0) begin errors++; $display("FAIL single_active_id got=%0d exp=0", bus.active_id); end
    req_v = '0;
    drive_req();
    wait_done(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_done got=none exp=pulse"); end
    checks++; if (bus.idle !== 1'b1) begin errors++; $display("FAIL single_idle got=%b exp=1", bus.idle); end
    repeat (5) step();
    checks++; if (n_start != 3) begin errors++; $display("FAIL single_start_len got=%0d exp=3", n_start); end
    checks++; if (n_ack != 1) begin errors++; $display("FAIL single_ack_len got=%0d exp=1", n_ack); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL single_done_cnt got=%0d exp=1", n_done); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int m_ptr, exp_id;
    do_reset();
    busy_delay = 1; frame_len = 3;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
    req_v = 4'b1111;
    drive_req();
    m_ptr = 0;
    for (int g = 0; g < 5; g++) begin
      exp_id = model_pick(req_v, m_ptr);
      wait_ack(20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rr_grant%0d got=none exp=ack", g); end
      checks++; if (bus.active_id !== ID_W'(exp_id)) begin errors++; $display("FAIL rr_id%0d got=%0d exp=%0d", g, bus.active_id, exp_id); end
      checks++; if (bus.tx_data !== bytes[exp_id]) begin errors++; $display("FAIL rr_data%0d got=%h exp=%h", g, bus.tx_data, bytes[exp_id]); end
      wait_done(40, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rr_done%0d got=none exp=pulse", g); end
      m_ptr = (exp_id + 1) % NUM_REQ;
    end
    req_v = '0;
    drive_req();
    repeat (3) step();
  endtask

  task automatic test_rotation();
    bit ok;
    do_reset();
    busy_delay = 1; frame_len = 2;
    for (int i = 0; i < NUM_REQ; i++) bytes[i] = WIDTH'($urandom);
    req_v = 4'b0100;
    drive_req();
    wait_ack(10, ok);
    checks++; if (bus.active_id !== 2'd2) begin errors++; $display("FAIL rot_first got=%0d exp=2", bus.active_id); end
    req_v = '0;
    drive_req();
    wait_done(40, ok);
    req_v = 4'b0101;
    drive_req();
    wait_ack(10, ok);
    checks++; if (bus.ack !== 4'b0001) begin errors++; $display("FAIL rot_next got=%b exp=0001", bus.ack); end
    checks++; if (bus.tx_data !== bytes[0]) begin errors++; $display("FAIL rot_data got=%h exp=%h", bus.tx_data, bytes[0]); end
    req_v = 4'b0100;
    drive_req();
    wait_done(40, ok);
    req_v = '0;
    drive_req();
    repeat (6) step();
  endtask

  task automatic test_timeout();
    bit ok;
    int ack_cyc;
    do_reset();
    busy_delay = -1;
    bytes[1] = WIDTH'($urandom);
    req_v = 4'b0010;
    drive_req();
    wait_ack(10, ok);
    ack_cyc = last_ack_cyc;
    checks++; if (bus.active_id !== 2'd1) begin errors++; $display("FAIL tmo_grant got=%0d exp=1", bus.active_id); end
    req_v = '0;
    drive_req();
    wait_tmo(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_pulse got=none exp=pulse"); end
    checks++; if (last_tmo_cyc - ack_cyc != TIMEOUT) begin errors++; $display("FAIL tmo_latency got=%0d exp=%0d", last_tmo_cyc - ack_cyc, TIMEOUT); end
    checks++; if (bus.err_sticky !== 1'b1) begin errors++; $display("FAIL tmo_sticky got=%b exp=1", bus.err_sticky); end
    checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL tmo_start_drop got=%b exp=0", bus.tx_start); end
    repeat (5) step();
    checks++; if (bus.err_sticky !== 1'b1) begin errors++; $display("FAIL tmo_sticky_hold got=%b exp=1", bus.err_sticky); end
    checks++; if (n_done != 0) begin errors++; $display("FAIL tmo_no_done got=%0d exp=0", n_done); end
    checks++; if (n_tmo != 1) begin errors++; $display("FAIL tmo_count got=%0d exp=1", n_tmo); end
    checks++; if (n_start != TIMEOUT) begin errors++; $display("FAIL tmo_start_len got=%0d exp=%0d", n_start, TIMEOUT); end
    checks++; if (bus.idle !== 1'b1) begin errors++; $display("FAIL tmo_idle got=%b exp=1", bus.idle); end
  endtask

  task automatic test_busy_boundary();
    bit ok;
    do_reset();
    busy_delay = TIMEOUT - 1; frame_len = 3;
    req_v = 4'b0001;
    drive_req();
    wait_ack(10, ok);
    req_v = '0;
    drive_req();
    wait_done(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bnd_done got=none exp=pulse"); end
    checks++; if (n_tmo != 0) begin errors++; $display("FAIL bnd_no_tmo got=%0d exp=0", n_tmo); end
    checks++; if (bus.err_sticky !== 1'b0) begin errors++; $display("FAIL bnd_sticky got=%b exp=0", bus.err_sticky); end
    checks++; if (n_start != TIMEOUT) begin errors++; $display("FAIL bnd_start_len got=%0d exp=%0d", n_start, TIMEOUT); end
    repeat (3) step();
    clear_obs();
    busy_delay = TIMEOUT;
    req_v = 4'b0001;
    drive_req();
    wait_ack(10, ok);
    req_v = '0;
    drive_req();
    repeat (TIMEOUT + 10) step();
    checks++; if (n_tmo != 1) begin errors++; $display("FAIL bnd_late_tmo got=%0d exp=1", n_tmo); end
    checks++; if (n_done != 0) begin errors++; $display("FAIL bnd_late_done got=%0d exp=0", n_done); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    do_reset();
    busy_delay = -1;
    req_v = 4'b0001;
    drive_req();
    wait_ack(10, ok);
    req_v = '0;
    drive_req();
    wait_tmo(40, ok);
    busy_delay = 0; frame_len = 40;
    req_v = 4'b0100;
    drive_req();
    wait_ack(10, ok);
    req_v = '0;
    drive_req();
    repeat (3) step();
    checks++; if (bus.idle !== 1'b0 || bus.tx_start !== 1'b0 || bus.err_sticky !== 1'b1) begin
      errors++; $display("FAIL rmf_pre idle=%b start=%b sticky=%b exp=0,0,1", bus.idle, bus.tx_start, bus.err_sticky);
    end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.idle !== 1'b1) begin errors++; $display("FAIL rmf_idle got=%b exp=1", bus.idle); end
    checks++; if (bus.ack !== '0) begin errors++; $display("FAIL rmf_ack got=%b exp=0", bus.ack); end
    checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL rmf_tx_start got=%b exp=0", bus.tx_start); end
    checks++; if (bus.tx_data !== '0) begin errors++; $display("FAIL rmf_tx_data got=%h exp=0", bus.tx_data); end
    checks++; if (bus.active_id !== '0) begin errors++; $display("FAIL rmf_active_id got=%0d exp=0", bus.active_id); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rmf_done got=%b exp=0", bus.done); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL rmf_timeout_err got=%b exp=0", bus.timeout_err); end
    checks++; if (bus.err_sticky !== 1'b0) begin errors++; $display("FAIL rmf_err_sticky got=%b exp=0", bus.err_sticky); end
    bus.tx_busy = 1'b0; seen = 0; busy_left = 0;
    busy_delay = 1; frame_len = 2;
    for (int i = 0; i < NUM_REQ; i++) bytes[i] = WIDTH'($urandom);
    req_v = 4'b1000;
    drive_req();
    @(negedge clk);
    rst = 1'b1;
    clear_obs();
    wait_ack(10, ok);
    checks++; if (bus.ack !== 4'b1000) begin errors++; $display("FAIL rmf_grant got=%b exp=1000", bus.ack); end
    checks++; if (bus.tx_data !== bytes[3]) begin errors++; $display("FAIL rmf_data got=%h exp=%h", bus.tx_data, bytes[3]); end
    req_v = '0;
    drive_req();
    wait_done(40, ok);
    req_v = 4'b1001;
    drive_req();
    wait_ack(10, ok);
    checks++; if (bus.active_id !== ID_W'(model_pick(4'b1001, 0))) begin
      errors++; $display("FAIL rmf_second got=%0d exp=%0d", bus.active_id, model_pick(4'b1001, 0));
    end
    req_v = 4'b1000;
    drive_req();
    wait_done(40, ok);
  endtask

  task automatic test_random();
    int m_ptr, m_id, exp_id, grants;
    bit m_idle;
    logic [NUM_REQ-1:0] exp_ack;
    do_reset();
    busy_delay = 0; frame_len = 1;
    m_ptr = 0; m_id = 0; m_idle = 1'b1; grants = 0;
    for (int it = 0; it < 3000 && grants < 30; it++) begin
      step();
      if (m_idle && req_v != '0) begin
        exp_id = model_pick(req_v, m_ptr);
        exp_ack = '0;
        exp_ack[exp_id] = 1'b1;
        checks++; if (bus.ack !== exp_ack) begin errors++; $display("FAIL rand_ack got=%b exp=%b", bus.ack, exp_ack); end
        checks++; if (bus.tx_data !== bytes[exp_id]) begin errors++; $display("FAIL rand_data got=%h exp=%h", bus.tx_data, bytes[exp_id]); end
        checks++; if (bus.active_id !== ID_W'(exp_id)) begin errors++; $display("FAIL rand_id got=%0d exp=%0d", bus.active_id, exp_id); end
        m_idle = 1'b0;
        m_id = exp_id;
        req_v[exp_id] = 1'b0;
      end else if (bus.ack != '0) begin
        checks++; errors++; $display("FAIL rand_spurious_ack got=%b exp=0", bus.ack);
      end
      if (bus.done) begin
        checks++; if (m_idle) begin errors++; $display("FAIL rand_spurious_done got=1 exp=0"); end
        m_ptr = (m_id + 1) % NUM_REQ;
        m_idle = 1'b1;
        grants++;
        busy_delay = $urandom_range(0, 4);
        frame_len = $urandom_range(1, 5);
      end
      if (bus.timeout_err) begin
        checks++; errors++; $display("FAIL rand_timeout got=1 exp=0");
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_v[i] && $urandom_range(0, 3) == 0) begin
          req_v[i] = 1'b1;
          bytes[i] = WIDTH'($urandom);
        end
      end
      drive_req();
    end
    checks++; if (grants < 30) begin errors++; $display("FAIL rand_progress got=%0d exp=30", grants); end
  endtask

  initial begin
    req_v = '0;
    for (int i = 0; i < NUM_REQ; i++) bytes[i] = '0;
    drive_req();
    bus.tx_busy = 1'b0;
    clear_obs();
    test_reset();
    test_single();
    test_round_robin();
    test_rotation();
    test_timeout();
    test_busy_boundary();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
